data_stack_16b: RTL and testbench

Hardware operand stack for the 16-bit stack-machine datapath. It sits directly downstream of the 8-way 16-bit source-select mux. The mux output (ALU result, memory read data, immediate, PC and so on) arrives on `din` and is pushed, replaced or merged according to a 3-bit stack opcode from control. The top two entries are always presented as `tos` and `nos` to feed the ALU and the mux inputs back.

---
 rtl/stack_pkg.sv | 14 +
 rtl/stack_spill_ram.sv | 22 ++
 rtl/data_stack_16b.sv | 148 ++++++++++++++
 tb/tb_data_stack_16b.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared opcode encodings and default geometry for the operand stack.
package stack_pkg;
  localparam int unsigned STACK_DEPTH = 16;
  localparam int unsigned STACK_WIDTH = 16;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_PUSH  = 3'b001;
  localparam logic [2:0] OP_POP   = 3'b010;
  localparam logic [2:0] OP_REPL  = 3'b011;
  localparam logic [2:0] OP_BINOP = 3'b100;
  localparam logic [2:0] OP_DUP   = 3'b101;
  localparam logic [2:0] OP_SWAP  = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;
endpackage

// File: rtl/stack_spill_ram.sv
// Spill storage for stack entries below tos/nos: one synchronous write
// port, one asynchronous read port, contents survive reset.
module stack_spill_ram #(
  parameter int unsigned NWORDS = 14,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned AW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic             CLK,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [NWORDS];

  always_ff @(posedge CLK) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/data_stack_16b.sv
// Operand stack: tos/nos in dedicated registers, deeper entries in the
// spill RAM. Every output is a register; failing ops only raise flags.
import stack_pkg::*;

module data_stack_16b #(
  parameter int unsigned DEPTH = STACK_DEPTH,
  parameter int unsigned WIDTH = STACK_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [WIDTH-1:0]           din,
  input  logic [2:0]                 op,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic                       err_ill
);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned NW = DEPTH - 2;
  localparam int unsigned AW = (NW > 1) ? $clog2(NW) : 1;

  localparam logic [CW-1:0] C_ZERO  = '0;
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_TWO   = CW'(2);
  localparam logic [CW-1:0] C_THREE = CW'(3);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_tos, r_nos;
  logic [CW-1:0]    r_count;
  logic             r_empty, r_full;
  logic             r_err_ovf, r_err_unf, r_err_ill;

  logic [WIDTH-1:0] w_tos_nx, w_nos_nx, w_rdata, w_spill_top;
  logic [CW-1:0]    w_count_nx;
  logic [AW-1:0]    w_waddr, w_raddr;
  logic             w_we, w_ovf, w_unf, w_ill;

  // With n entries the spill RAM holds n-2 words; index n-3 is its top and
  // a push writes the outgoing nos to index n-2.
  assign w_waddr     = AW'(r_count - C_TWO);
  assign w_raddr     = AW'(r_count - C_THREE);
  assign w_spill_top = (r_count > C_TWO) ? w_rdata : '0;

  stack_spill_ram #(
    .NWORDS (NW),
    .WIDTH  (WIDTH),
    .AW     (AW)
  ) u_spill (
    .CLK     (CLK),
    .i_we    (w_we & RESET_N),
    .i_waddr (w_waddr),
    .i_wdata (r_nos),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_tos_nx   = r_tos;
    w_nos_nx   = r_nos;
    w_count_nx = r_count;
    w_we       = 1'b0;
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    w_ill      = 1'b0;
    case (op)
      OP_NOP: ;
      OP_PUSH: begin
        if (r_count != C_DEPTH) begin
          w_we       = (r_count >= C_TWO);
          w_nos_nx   = r_tos;
          w_tos_nx   = din;
          w_count_nx = r_count + C_ONE;
        end else w_ovf = 1'b1;
      end
      OP_POP: begin
        if (r_count != C_ZERO) begin
          w_tos_nx   = r_nos;
          w_nos_nx   = w_spill_top;
          w_count_nx = r_count - C_ONE;
        end else w_unf = 1'b1;
      end
      OP_REPL: begin
        if (r_count != C_ZERO) w_tos_nx = din;
        else                   w_unf    = 1'b1;
      end
      OP_BINOP: begin
        if (r_count >= C_TWO) begin
          w_tos_nx   = din;
          w_nos_nx   = w_spill_top;
          w_count_nx = r_count - C_ONE;
        end else w_unf = 1'b1;
      end
      OP_DUP: begin
        if (r_count == C_ZERO) w_unf = 1'b1;
        else if (r_count == C_DEPTH) w_ovf = 1'b1;
        else begin
          w_we       = (r_count >= C_TWO);
          w_nos_nx   = r_tos;
          w_count_nx = r_count + C_ONE;
        end
      end
      OP_SWAP: begin
        if (r_count >= C_TWO) begin
          w_tos_nx = r_nos;
          w_nos_nx = r_tos;
        end else w_unf = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_tos     <= '0;
      r_nos     <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_full    <= 1'b0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
      r_err_ill <= 1'b0;
    end else begin
      r_tos     <= w_tos_nx;
      r_nos     <= w_nos_nx;
      r_count   <= w_count_nx;
      r_empty   <= (w_count_nx == C_ZERO);
      r_full    <= (w_count_nx == C_DEPTH);
      // A clear keeps only flags raised by this cycle's op.
      r_err_ovf <= clr_err ? w_ovf : (r_err_ovf | w_ovf);
      r_err_unf <= clr_err ? w_unf : (r_err_unf | w_unf);
      r_err_ill <= clr_err ? w_ill : (r_err_ill | w_ill);
    end
  end

  assign tos     = r_tos;
  assign nos     = r_nos;
  assign count   = r_count;
  assign empty   = r_empty;
  assign full    = r_full;
  assign err_ovf = r_err_ovf;
  assign err_unf = r_err_unf;
  assign err_ill = r_err_ill;
endmodule

// File: tb/tb_data_stack_16b.sv
// Directed bench for data_stack_16b: a queue-based reference stack checked
// every cycle, plus literal expectations from hand-worked sequences.
module tb_data_stack_16b;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 16;

  logic             CLK = 1'b0;
  logic             RESET_N = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [2:0]       op = 3'b000;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] tos, nos;
  logic [4:0]       count;
  logic             empty, full, err_ovf, err_unf, err_ill;

  data_stack_16b #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .din(din), .op(op), .clr_err(clr_err),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_ill(err_ill)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [WIDTH-1:0] q[$];
  bit m_ovf = 0, m_unf = 0, m_ill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_apply(input logic [2:0] o, input logic [WIDTH-1:0] d,
                                      input logic c, input logic rst_n);
    logic [WIDTH-1:0] a, b;
    bit ovf, unf, ill;
    int n;
    if (!rst_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_ill = 0;
      return;
    end
    ovf = 0; unf = 0; ill = 0;
    n = q.size();
    case (o)
      3'd1: if (n < DEPTH) q.push_back(d); else ovf = 1;
      3'd2: if (n >= 1) void'(q.pop_back()); else unf = 1;
      3'd3: if (n >= 1) q[n-1] = d; else unf = 1;
      3'd4: if (n >= 2) begin void'(q.pop_back()); void'(q.pop_back()); q.push_back(d); end
            else unf = 1;
      3'd5: if (n == 0) unf = 1; else if (n == DEPTH) ovf = 1; else q.push_back(q[n-1]);
      3'd6: if (n >= 2) begin a = q[n-1]; b = q[n-2]; q[n-1] = b; q[n-2] = a; end
            else unf = 1;
      3'd7: ill = 1;
      default: ;
    endcase
    m_ovf = c ? ovf : (m_ovf | ovf);
    m_unf = c ? unf : (m_unf | unf);
    m_ill = c ? ill : (m_ill | ill);
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("tos",     32'(tos),     (q.size() > 0) ? 32'(q[q.size()-1]) : 32'd0);
      chk("nos",     32'(nos),     (q.size() > 1) ? 32'(q[q.size()-2]) : 32'd0);
      chk("count",   32'(count),   32'(q.size()));
      chk("empty",   32'(empty),   32'(q.size() == 0));
      chk("full",    32'(full),    32'(q.size() == DEPTH));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_unf", 32'(err_unf), 32'(m_unf));
      chk("err_ill", 32'(err_ill), 32'(m_ill));
    end
  end

  task automatic step(input logic [2:0] o, input logic [WIDTH-1:0] d, input logic c = 1'b0);
    op = o; din = d; clr_err = c;
    @(posedge CLK);
    model_apply(o, d, c, RESET_N);
    #1;
    op = 3'd0; clr_err = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0;
    step(3'd0, '0);
    step(3'd0, '0);
    RESET_N = 1'b1;
    chk_en = 1'b1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_tos",   32'(tos),   32'd0);
    chk("rst_flags", {29'd0, err_ovf, err_unf, err_ill}, 32'd0);

    step(3'd1, 16'h1111); step(3'd1, 16'h2222); step(3'd1, 16'h3333);
    chk("p3_tos", 32'(tos), 32'h3333);
    chk("p3_nos", 32'(nos), 32'h2222);
    chk("p3_cnt", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(3'd2, '0);
    chk("pop_tos", 32'(tos), 32'd0);
    chk("pop_empty", 32'(empty), 32'd1);
    chk("pop_flags", {29'd0, err_ovf, err_unf, err_ill}, 32'd0);

    step(3'd1, 16'h0005); step(3'd1, 16'h0007); step(3'd4, 16'h000C);
    chk("bin_tos", 32'(tos), 32'h000C);
    chk("bin_nos", 32'(nos), 32'd0);
    chk("bin_cnt", 32'(count), 32'd1);
    step(3'd6, '0);
    chk("swap1_unf", 32'(err_unf), 32'd1);
    chk("swap1_tos", 32'(tos), 32'h000C);
    step(3'd2, '0, 1'b1);

    // Deeper stack: swap and binop with a spilled entry underneath.
    step(3'd1, 16'hA001); step(3'd1, 16'hA002); step(3'd1, 16'hA003);
    step(3'd6, '0);
    chk("swap3_tos", 32'(tos), 32'hA002);
    chk("swap3_nos", 32'(nos), 32'hA003);
    step(3'd4, 16'h0BAD);
    chk("bin3_tos", 32'(tos), 32'h0BAD);
    chk("bin3_nos", 32'(nos), 32'hA001);
    step(3'd2, '0); step(3'd2, '0);

    for (int i = 1; i <= 16; i++) step(3'd1, 16'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_tos",  32'(tos),  32'd16);
    step(3'd1, 16'hBEEF);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_tos",  32'(tos),     32'd16);
    chk("ovf_cnt",  32'(count),   32'd16);
    for (int i = 16; i >= 1; i--) begin
      chk("drain_tos", 32'(tos), 32'(i));
      step(3'd2, '0);
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(3'd0, '0, 1'b1);

    step(3'd1, 16'hAAAA); step(3'd5, '0); step(3'd3, 16'h5555);
    chk("rep_tos", 32'(tos), 32'h5555);
    chk("rep_nos", 32'(nos), 32'hAAAA);
    step(3'd7, 16'hFFFF);
    chk("ill_flag", 32'(err_ill), 32'd1);
    chk("ill_tos",  32'(tos), 32'h5555);
    chk("ill_nos",  32'(nos), 32'hAAAA);
    step(3'd2, '0); step(3'd2, '0);

    step(3'd2, '0);
    chk("unf_set", 32'(err_unf), 32'd1);
    step(3'd2, '0, 1'b1);
    chk("clr_same_cycle", {29'd0, err_ovf, err_unf, err_ill}, 32'b010);
    step(3'd0, '0, 1'b1);
    chk("clr_only", {29'd0, err_ovf, err_unf, err_ill}, 32'd0);

    for (int i = 0; i < 5; i++) step(3'd1, 16'h1234);
    chk("pre_rst_cnt", 32'(count), 32'd5);
    RESET_N = 1'b0;
    step(3'd1, 16'h9999);
    RESET_N = 1'b1;
    chk("mid_rst_cnt", 32'(count), 32'd0);
    chk("mid_rst_tos", 32'(tos), 32'd0);
    step(3'd1, 16'h0001);
    chk("post_rst_cnt", 32'(count), 32'd1);
    chk("post_rst_nos", 32'(nos), 32'd0);

    @(negedge CLK);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
